// File: rtl/rr_merge_arbiter.sv
// Round-robin merge of SIZE handshake producers into one registered output slot.
// The winner's data and channel number are captured into the slot, which drains and refills in the same cycle.
module rr_merge_arbiter #(
  parameter int SIZE        = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SIZE*DATA_WIDTH-1:0] ins,
  input  logic [SIZE-1:0]            ins_valid,
  output logic [SIZE-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]      outs,
  output logic                       outs_valid,
  input  logic                       outs_ready,
  output logic [INDEX_WIDTH-1:0]     index
);

  localparam int PW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int EXT = 2 ** (PW + 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t            r_state;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [PW-1:0]          r_ptr;

  logic [EXT-1:0]         w_valid_ext;
  logic [PW:0]            w_cand;
  logic                   w_found;
  logic [PW-1:0]          w_win;
  logic [SIZE-1:0]        w_ready_oh;
  logic [DATA_WIDTH-1:0]  w_data;
  logic                   w_accept;
  logic                   w_grant;
  logic [PW-1:0]          w_ptr_next;

  // Padding the valid vector lets a candidate of full index width address it safely.
  assign w_valid_ext = EXT'(ins_valid);

  // Circular search for the first valid channel, starting at the priority pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < SIZE; k++) begin
      w_cand = {1'b0, r_ptr} + (PW + 1)'(k);
      if (w_cand >= (PW + 1)'(SIZE)) begin
        w_cand = w_cand - (PW + 1)'(SIZE);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && w_valid_ext[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand[PW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Decode the winner into a one-hot grant and select its data.
  always_comb begin
    w_ready_oh = '0;
    w_data     = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (w_win == PW'(i)) begin
        w_ready_oh[i] = 1'b1;
        w_data        = ins[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_ready_oh[i] = 1'b0;
      end
    end
  end

  assign w_accept   = (r_state == S_EMPTY) || outs_ready;
  assign w_grant    = rst && w_accept && w_found;
  assign w_ptr_next = (w_win == PW'(SIZE - 1)) ? '0 : w_win + PW'(1);
  assign ins_ready  = w_grant ? w_ready_oh : '0;

  // Slot FSM plus the data, index and pointer registers that follow a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_index <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: r_state <= w_found ? S_FULL : S_EMPTY;
        S_FULL:  r_state <= (outs_ready && !w_found) ? S_EMPTY : S_FULL;
        default: r_state <= S_EMPTY;
      endcase
      if (w_grant) begin
        r_data  <= w_data;
        r_index <= INDEX_WIDTH'(w_win);
        r_ptr   <= w_ptr_next;
      end else begin
        r_data  <= r_data;
        r_index <= r_index;
        r_ptr   <= r_ptr;
      end
    end
  end

  assign outs       = r_data;
  assign index      = r_index;
  assign outs_valid = (r_state == S_FULL);

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Randomized and directed bench for rr_merge_arbiter (SIZE=3) against a transaction-level model.
module tb_rr_merge_arbiter;

  localparam int SIZE = 3;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic                 clk;
  logic                 rst;
  logic [SIZE*DW-1:0]   ins;
  logic [SIZE-1:0]      ins_valid;
  logic [SIZE-1:0]      ins_ready;
  logic [DW-1:0]        outs;
  logic                 outs_valid;
  logic                 outs_ready;
  logic [IW-1:0]        index;

  int n_checks;
  int n_fail;

  // Reference model: the slot contents and the next channel to favour.
  int       m_ptr;
  logic     m_valid;
  logic [7:0] m_data;
  int       m_idx;
  int       last_grant;

  logic [SIZE-1:0] pend;
  logic [7:0]      pdata [SIZE];

  localparam logic [23:0] ABC = {8'hC2, 8'hB1, 8'hA0};

  rr_merge_arbiter #(.SIZE(SIZE), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .index      (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic do_cycle(input logic rv, input logic [2:0] v, input logic [23:0] d, input logic ordy);
    logic       acc;
    int         win;
    int         c;
    logic [2:0] exp_ready;
    @(negedge clk);
    rst        = rv;
    ins_valid  = v;
    ins        = d;
    outs_ready = ordy;
    #1;
    acc = !m_valid || ordy;
    win = -1;
    for (int k = 0; k < SIZE; k++) begin
      c = (m_ptr + k) % SIZE;
      if (win < 0 && v[c]) win = c;
    end
    exp_ready = (rv && acc && win >= 0) ? 3'(1 << win) : 3'b000;
    check("ins_ready", 32'(ins_ready), 32'(exp_ready));
    check("outs_valid", 32'(outs_valid), 32'(m_valid));
    check("outs", 32'(outs), 32'(m_data));
    check("index", 32'(index), 32'(m_idx));
    @(posedge clk);
    last_grant = -1;
    if (!rv) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (exp_ready != 3'b000) begin
      m_data     = d[win*8 +: 8];
      m_idx      = win;
      m_valid    = 1'b1;
      m_ptr      = (win + 1) % SIZE;
      last_grant = win;
    end else if (acc) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]  v;
    logic [23:0] d;
    logic        ordy;
    logic        rv;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    ins        = ABC;
    ins_valid  = 3'b111;
    outs_ready = 1'b1;
    pend       = '0;
    @(posedge clk);
    m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_idx = 0; last_grant = -1;

    // Reset held with all requests up, then release.
    do_cycle(1'b0, 3'b111, ABC, 1'b1);
    do_cycle(1'b0, 3'b111, ABC, 1'b1);
    // Round robin across all three, consumer always ready.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 3'b111, ABC, 1'b1);
    do_cycle(1'b1, 3'b000, ABC, 1'b1);
    do_cycle(1'b1, 3'b000, ABC, 1'b1);
    // Backpressure: fill with in0 then stall, then drain while in1 requests.
    do_cycle(1'b1, 3'b001, ABC, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 3'b011, ABC, 1'b0);
    do_cycle(1'b1, 3'b010, ABC, 1'b1);
    do_cycle(1'b1, 3'b000, ABC, 1'b1);
    // Sparse and wrap: only in2, then in0 and in2 together.
    do_cycle(1'b1, 3'b100, ABC, 1'b1);
    do_cycle(1'b1, 3'b101, ABC, 1'b1);
    do_cycle(1'b1, 3'b100, ABC, 1'b1);
    // Idle drain leaves outs holding the last value.
    do_cycle(1'b1, 3'b000, ABC, 1'b1);
    do_cycle(1'b1, 3'b000, ABC, 1'b1);
    // Mid-operation reset while the slot is stalled.
    do_cycle(1'b1, 3'b010, ABC, 1'b1);
    do_cycle(1'b1, 3'b000, ABC, 1'b0);
    do_cycle(1'b0, 3'b000, ABC, 1'b0);
    do_cycle(1'b1, 3'b000, ABC, 1'b1);
    do_cycle(1'b1, 3'b110, ABC, 1'b1);
    do_cycle(1'b1, 3'b000, ABC, 1'b1);

    // Random traffic with producers holding requests until transferred.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 50) begin
          pend[i]  = 1'b1;
          pdata[i] = 8'($urandom);
        end
      end
      d = 24'($urandom);
      for (int i = 0; i < SIZE; i++) begin
        if (pend[i]) d[i*8 +: 8] = pdata[i];
      end
      v    = pend;
      ordy = ($urandom_range(0, 99) < 70);
      rv   = ($urandom_range(0, 199) != 0);
      do_cycle(rv, v, d, ordy);
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
